// File: rtl/anffl_tex_quad_addr_gen.sv
// Texel / 2x2-quad byte-address generator for linear, ETC2/EAC block and 16x16-tiled textures.
// Tiled formats are generated only when ANFFL_TEX_TILED_EN is defined; otherwise they report out_fmt_err.
module anffl_tex_quad_addr_gen #(
  parameter int ADDR_W  = 32,
  parameter int COORD_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic [63:0]        in_meta,
  input  logic               in_bilinear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [3:0]         out_x_texel,
  output logic [3:0]         out_y_texel,
  output logic [1:0]         out_idx,
  output logic               out_last,
  output logic               out_fmt_err
);

  // Coordinate arithmetic width: holds coord+1 and any mask up to 2^15-1.
  localparam int CW = 17;

  typedef enum logic {IDLE, EMIT} stateT;
  stateT state;

  logic [COORD_W-1:0] xReg, yReg;
  logic [4:0]         fmtReg;
  logic [3:0]         hExpReg, wExpReg;
  logic               clampReg, bilReg;
  logic [31:0]        baseReg;

  logic               accept;
  logic [COORD_W-1:0] selX, selY;
  logic [4:0]         selFmt;
  logic [3:0]         selHExp, selWExp;
  logic               selClamp, selBil;
  logic [31:0]        selBase;
  logic [1:0]         selIdx;

  logic [CW-1:0]      cx, cy, maskX, maskY, fx, fy;
  logic [ADDR_W-1:0]  ax, ay, pLin, bIdx, offset, beatAddr;
  logic               beatErr, beatLast;
`ifdef ANFFL_TEX_TILED_EN
  logic [ADDR_W-1:0]  tIdx, pTile;
`endif

  logic unusedMetaBits;
  assign unusedMetaBits = ^in_meta[31:14];

  assign in_ready = (state == IDLE) || (out_last && out_ready);
  assign accept   = in_valid && in_ready;

  // The beat being loaded is either beat 0 of a newly accepted request or the next beat of the held one.
  always_comb begin
    if (accept) begin
      selX     = in_x;
      selY     = in_y;
      selFmt   = in_meta[4:0];
      selHExp  = in_meta[8:5];
      selWExp  = in_meta[12:9];
      selClamp = in_meta[13];
      selBil   = in_bilinear;
      selBase  = in_meta[63:32];
      selIdx   = 2'd0;
    end else begin
      selX     = xReg;
      selY     = yReg;
      selFmt   = fmtReg;
      selHExp  = hExpReg;
      selWExp  = wExpReg;
      selClamp = clampReg;
      selBil   = bilReg;
      selBase  = baseReg;
      selIdx   = out_idx + 2'd1;
    end
  end

  always_comb begin
    cx    = CW'(selX) + CW'(selIdx[0]);
    cy    = CW'(selY) + CW'(selIdx[1]);
    maskX = (CW'(1) << selWExp) - CW'(1);
    maskY = (CW'(1) << selHExp) - CW'(1);
    if (selClamp) begin
      fx = (cx > maskX) ? maskX : cx;
      fy = (cy > maskY) ? maskY : cy;
    end else begin
      fx = cx & maskX;
      fy = cy & maskY;
    end
  end

  always_comb begin
    ax   = ADDR_W'(fx);
    ay   = ADDR_W'(fy);
    pLin = (ay << selWExp) + ax;
    bIdx = (ADDR_W'(fy >> 2) << (selWExp - 4'd2)) | ADDR_W'(fx >> 2);
`ifdef ANFFL_TEX_TILED_EN
    tIdx  = (ADDR_W'(fy >> 4) << (selWExp - 4'd4)) | ADDR_W'(fx >> 4);
    pTile = (tIdx << 8) | (ADDR_W'(fy[3:0]) << 4) | ADDR_W'(fx[3:0]);
`endif
  end

  always_comb begin
    offset  = '0;
    beatErr = 1'b0;
    casez (selFmt)
      5'b00000: offset = (pLin << 1) + pLin;
      5'b00100: offset = pLin << 2;
      5'b???01: offset = pLin << 1;
      5'b00010, 5'b10010: begin
        beatErr = (selWExp < 4'd2);
        offset  = bIdx << 3;
      end
      5'b00110: begin
        beatErr = (selWExp < 4'd2);
        offset  = bIdx << 4;
      end
`ifdef ANFFL_TEX_TILED_EN
      5'b00011, 5'b00111, 5'b01011, 5'b01111, 5'b10111, 5'b10011: begin
        beatErr = (selWExp < 4'd4);
        case (selFmt)
          5'b00011: offset = (pTile << 1) + pTile;
          5'b00111: offset = pTile << 2;
          5'b10011: offset = pTile;
          default:  offset = pTile << 1;
        endcase
      end
`endif
      default: beatErr = 1'b1;
    endcase
    beatAddr = beatErr ? ADDR_W'(selBase) : ADDR_W'(selBase) + offset;
    beatLast = selBil ? (selIdx == 2'd3) : (selIdx == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_fmt_err <= 1'b0;
      out_idx     <= '0;
      out_addr    <= '0;
      out_x_texel <= '0;
      out_y_texel <= '0;
      xReg        <= '0;
      yReg        <= '0;
      fmtReg      <= '0;
      hExpReg     <= '0;
      wExpReg     <= '0;
      clampReg    <= 1'b0;
      bilReg      <= 1'b0;
      baseReg     <= '0;
    end else if (accept) begin
      xReg        <= in_x;
      yReg        <= in_y;
      fmtReg      <= in_meta[4:0];
      hExpReg     <= in_meta[8:5];
      wExpReg     <= in_meta[12:9];
      clampReg    <= in_meta[13];
      bilReg      <= in_bilinear;
      baseReg     <= in_meta[63:32];
      state       <= EMIT;
      out_valid   <= 1'b1;
      out_idx     <= selIdx;
      out_addr    <= beatAddr;
      out_x_texel <= fx[3:0];
      out_y_texel <= fy[3:0];
      out_fmt_err <= beatErr;
      out_last    <= beatLast;
    end else if (state == EMIT && out_ready) begin
      if (out_last) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        out_idx     <= selIdx;
        out_addr    <= beatAddr;
        out_x_texel <= fx[3:0];
        out_y_texel <= fy[3:0];
        out_fmt_err <= beatErr;
        out_last    <= beatLast;
      end
    end
  end

endmodule

// File: tb/tb_anffl_tex_quad_addr_gen.sv
// Scoreboard bench for anffl_tex_quad_addr_gen; tiled expectations follow ANFFL_TEX_TILED_EN.
module tb_anffl_tex_quad_addr_gen;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_bilinear, out_valid, out_ready, out_last, out_fmt_err;
  logic [15:0] in_x, in_y;
  logic [63:0] in_meta;
  logic [31:0] out_addr;
  logic [3:0]  out_x_texel, out_y_texel;
  logic [1:0]  out_idx;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  xt;
    logic [3:0]  yt;
    logic [1:0]  idx;
    logic        last;
    logic        err;
  } beatT;

  beatT expQ[$];
  beatT gotQ[$];
  int   checks = 0;
  int   errors = 0;
  bit   done;
  logic [4:0] fmtTab [11] = '{5'b00000, 5'b00100, 5'b00001, 5'b01101, 5'b00010, 5'b10010,
                              5'b00110, 5'b00011, 5'b10011, 5'b11111, 5'b01000};

  anffl_tex_quad_addr_gen #(.ADDR_W(32), .COORD_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_meta(in_meta), .in_bilinear(in_bilinear),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_x_texel(out_x_texel), .out_y_texel(out_y_texel), .out_idx(out_idx),
    .out_last(out_last), .out_fmt_err(out_fmt_err)
  );

  always #5 clk = ~clk;

  // Capture every transferred beat mid-cycle.
  always @(negedge clk)
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1)
      gotQ.push_back({out_addr, out_x_texel, out_y_texel, out_idx, out_last, out_fmt_err});

  function automatic logic [63:0] makeMeta(input logic [31:0] base, input logic [4:0] fmt,
                                           input int we, input int he, input logic clamp);
    return {base, 18'd0, clamp, 4'(we), 4'(he), fmt};
  endfunction

  function automatic beatT modelBeat(input logic [15:0] x, input logic [15:0] y,
                                     input logic [63:0] meta, input logic bil, input int idx);
    beatT b;
    int we, he;
    longint mx, my, cx, cy, fx, fy, p, blk, t, pt, off;
    logic [4:0] f;
    logic err;
    f  = meta[4:0];
    he = int'(meta[8:5]);
    we = int'(meta[12:9]);
    mx = (longint'(1) << we) - 1;
    my = (longint'(1) << he) - 1;
    cx = longint'(x) + (idx % 2);
    cy = longint'(y) + (idx / 2);
    if (meta[13]) begin
      fx = (cx > mx) ? mx : cx;
      fy = (cy > my) ? my : cy;
    end else begin
      fx = cx % (mx + 1);
      fy = cy % (my + 1);
    end
    p   = fy * (longint'(1) << we) + fx;
    blk = (we >= 2) ? (fy / 4) * (longint'(1) << (we - 2)) + fx / 4 : 0;
    t   = (we >= 4) ? (fy / 16) * (longint'(1) << (we - 4)) + fx / 16 : 0;
    pt  = t * 256 + (fy % 16) * 16 + (fx % 16);
    err = 1'b0;
    off = 0;
    case (f)
      5'b00000: off = 3 * p;
      5'b00100: off = 4 * p;
      5'b00010, 5'b10010: begin err = (we < 2); off = 8 * blk; end
      5'b00110: begin err = (we < 2); off = 16 * blk; end
`ifdef ANFFL_TEX_TILED_EN
      5'b00011: begin err = (we < 4); off = 3 * pt; end
      5'b00111: begin err = (we < 4); off = 4 * pt; end
      5'b01011, 5'b01111, 5'b10111: begin err = (we < 4); off = 2 * pt; end
      5'b10011: begin err = (we < 4); off = pt; end
`endif
      default: if (f[1:0] == 2'b01) off = 2 * p; else err = 1'b1;
    endcase
    b.addr = err ? meta[63:32] : 32'(longint'(meta[63:32]) + off);
    b.xt   = 4'(fx);
    b.yt   = 4'(fy);
    b.idx  = 2'(idx);
    b.last = bil ? (idx == 3) : (idx == 0);
    b.err  = err;
    return b;
  endfunction

  task automatic pushModel(input logic [15:0] x, input logic [15:0] y, input logic [63:0] meta, input logic bil);
    for (int i = 0; i < (bil ? 4 : 1); i++) expQ.push_back(modelBeat(x, y, meta, bil, i));
  endtask

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic sendReq(input logic [15:0] x, input logic [15:0] y, input logic [63:0] meta,
                         input logic bil, output int waited);
    logic acc;
    in_x = x; in_y = y; in_meta = meta; in_bilinear = bil; in_valid = 1'b1; waited = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      waited++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_x = '0; in_y = '0; in_meta = '0; in_bilinear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_last, out_fmt_err, out_idx, out_addr, out_x_texel, out_y_texel} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b last=%b err=%b idx=%0d addr=%h xt=%h yt=%h want all zero",
               out_valid, out_last, out_fmt_err, out_idx, out_addr, out_x_texel, out_y_texel);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_point_linear();
    int w;
    beatT e, g;
    expQ.delete(); gotQ.delete();
    expQ.push_back(beatT'{32'h1000080C, 4'd3, 4'd2, 2'd0, 1'b1, 1'b0});
    expQ.push_back(beatT'{32'h000000DF, 4'd5, 4'd6, 2'd0, 1'b1, 1'b0});
    sendReq(16'd3, 16'd2, makeMeta(32'h10000000, 5'b00100, 8, 8, 1'b0), 1'b0, w);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL point_latency got out_valid=%b want 1", out_valid); end
    sendReq(16'd5, 16'd6, makeMeta(32'h00000040, 5'b00000, 3, 3, 1'b0), 1'b0, w);
    checks++;
    if (w !== 0) begin errors++; $display("FAIL point_no_bubble got wait=%0d want 0", w); end
    for (int c = 0; c < 50 && gotQ.size() < expQ.size(); c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (gotQ.size() != expQ.size()) begin errors++; $display("FAIL point_count got %0d want %0d", gotQ.size(), expQ.size()); end
    while (expQ.size() > 0 && gotQ.size() > 0) begin
      e = expQ.pop_front(); g = gotQ.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL point_beat got addr=%h xt=%h yt=%h idx=%0d last=%b err=%b want addr=%h xt=%h yt=%h idx=%0d last=%b err=%b", g.addr, g.xt, g.yt, g.idx, g.last, g.err, e.addr, e.xt, e.yt, e.idx, e.last, e.err); end
      else $display("point beat addr=%h idx=%0d", g.addr, g.idx);
    end
  endtask

  task automatic test_quad_wrap_clamp();
    int w;
    beatT e, g;
    expQ.delete(); gotQ.delete();
    expQ.push_back(beatT'{32'h1FE, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0});
    expQ.push_back(beatT'{32'h000, 4'h0, 4'h0, 2'd1, 1'b0, 1'b0});
    expQ.push_back(beatT'{32'h3FE, 4'hF, 4'h1, 2'd2, 1'b0, 1'b0});
    expQ.push_back(beatT'{32'h200, 4'h0, 4'h1, 2'd3, 1'b1, 1'b0});
    expQ.push_back(beatT'{32'h1FE, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0});
    expQ.push_back(beatT'{32'h1FE, 4'hF, 4'h0, 2'd1, 1'b0, 1'b0});
    expQ.push_back(beatT'{32'h3FE, 4'hF, 4'h1, 2'd2, 1'b0, 1'b0});
    expQ.push_back(beatT'{32'h3FE, 4'hF, 4'h1, 2'd3, 1'b1, 1'b0});
    sendReq(16'd255, 16'd0, makeMeta(32'h0, 5'b00001, 8, 8, 1'b0), 1'b1, w);
    sendReq(16'd255, 16'd0, makeMeta(32'h0, 5'b00001, 8, 8, 1'b1), 1'b1, w);
    for (int c = 0; c < 50 && gotQ.size() < expQ.size(); c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (gotQ.size() != expQ.size()) begin errors++; $display("FAIL quad_count got %0d want %0d", gotQ.size(), expQ.size()); end
    while (expQ.size() > 0 && gotQ.size() > 0) begin
      e = expQ.pop_front(); g = gotQ.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL quad_beat got addr=%h xt=%h yt=%h idx=%0d last=%b err=%b want addr=%h xt=%h yt=%h idx=%0d last=%b err=%b", g.addr, g.xt, g.yt, g.idx, g.last, g.err, e.addr, e.xt, e.yt, e.idx, e.last, e.err); end
      else $display("quad beat addr=%h idx=%0d", g.addr, g.idx);
    end
  endtask

  task automatic test_tiled();
    int w;
    beatT e, g;
    expQ.delete(); gotQ.delete();
`ifdef ANFFL_TEX_TILED_EN
    expQ.push_back(beatT'{32'h521, 4'd1, 4'd2, 2'd0, 1'b1, 1'b0});
`else
    expQ.push_back(beatT'{32'h000, 4'd1, 4'd2, 2'd0, 1'b1, 1'b1});
`endif
    expQ.push_back(beatT'{32'h500, 4'd1, 4'd1, 2'd0, 1'b1, 1'b1});
    sendReq(16'd17, 16'd18, makeMeta(32'h0, 5'b10011, 6, 6, 1'b0), 1'b0, w);
    sendReq(16'd1, 16'd1, makeMeta(32'h500, 5'b00111, 3, 3, 1'b0), 1'b0, w);
    for (int c = 0; c < 50 && gotQ.size() < expQ.size(); c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (gotQ.size() != expQ.size()) begin errors++; $display("FAIL tiled_count got %0d want %0d", gotQ.size(), expQ.size()); end
    while (expQ.size() > 0 && gotQ.size() > 0) begin
      e = expQ.pop_front(); g = gotQ.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL tiled_beat got addr=%h xt=%h yt=%h idx=%0d last=%b err=%b want addr=%h xt=%h yt=%h idx=%0d last=%b err=%b", g.addr, g.xt, g.yt, g.idx, g.last, g.err, e.addr, e.xt, e.yt, e.idx, e.last, e.err); end
      else $display("tiled beat addr=%h err=%b", g.addr, g.err);
    end
  endtask

  task automatic test_compressed();
    int w;
    beatT e, g;
    expQ.delete(); gotQ.delete();
    expQ.push_back(beatT'{32'h00000048, 4'd5, 4'd9, 2'd0, 1'b1, 1'b0});
    expQ.push_back(beatT'{32'h00000000, 4'd1, 4'd9, 2'd0, 1'b1, 1'b1});
    expQ.push_back(beatT'{32'h00000190, 4'd5, 4'd9, 2'd0, 1'b1, 1'b0});
    expQ.push_back(beatT'{32'h00000048, 4'd5, 4'd9, 2'd0, 1'b1, 1'b0});
    expQ.push_back(beatT'{32'hABCD0000, 4'd5, 4'd9, 2'd0, 1'b1, 1'b1});
    sendReq(16'd5, 16'd9, makeMeta(32'h0, 5'b00010, 4, 4, 1'b0), 1'b0, w);
    sendReq(16'd5, 16'd9, makeMeta(32'h0, 5'b00010, 1, 4, 1'b0), 1'b0, w);
    sendReq(16'd5, 16'd9, makeMeta(32'h100, 5'b00110, 4, 4, 1'b0), 1'b0, w);
    sendReq(16'd5, 16'd9, makeMeta(32'h0, 5'b10010, 4, 4, 1'b0), 1'b0, w);
    sendReq(16'd5, 16'd9, makeMeta(32'hABCD0000, 5'b11000, 4, 4, 1'b0), 1'b0, w);
    for (int c = 0; c < 50 && gotQ.size() < expQ.size(); c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (gotQ.size() != expQ.size()) begin errors++; $display("FAIL compressed_count got %0d want %0d", gotQ.size(), expQ.size()); end
    while (expQ.size() > 0 && gotQ.size() > 0) begin
      e = expQ.pop_front(); g = gotQ.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL compressed_beat got addr=%h xt=%h yt=%h idx=%0d last=%b err=%b want addr=%h xt=%h yt=%h idx=%0d last=%b err=%b", g.addr, g.xt, g.yt, g.idx, g.last, g.err, e.addr, e.xt, e.yt, e.idx, e.last, e.err); end
      else $display("compressed beat addr=%h err=%b", g.addr, g.err);
    end
  endtask

  task automatic test_backpressure();
    int w;
    beatT e, g;
    logic [44:0] snap;
    logic [63:0] m1, m2;
    expQ.delete(); gotQ.delete();
    m1 = makeMeta(32'h2000, 5'b00100, 4, 4, 1'b0);
    m2 = makeMeta(32'h0, 5'b00001, 4, 4, 1'b0);
    pushModel(16'd2, 16'd3, m1, 1'b1);
    pushModel(16'd1, 16'd1, m2, 1'b0);
    out_ready = 1'b1;
    sendReq(16'd2, 16'd3, m1, 1'b1, w);
    @(posedge clk); #1;
    checks++;
    if (out_idx !== 2'd1) begin errors++; $display("FAIL stall_idx got %0d want 1", out_idx); end
    out_ready = 1'b0;
    snap = {out_valid, out_addr, out_x_texel, out_y_texel, out_idx, out_last, out_fmt_err};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_addr, out_x_texel, out_y_texel, out_idx, out_last, out_fmt_err} !== snap) begin
        errors++;
        $display("FAIL stall_stable got valid=%b addr=%h idx=%0d want valid=1 addr=%h idx=1", out_valid, out_addr, out_idx, snap[43:12]);
      end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && !(out_valid === 1'b1 && out_idx === 2'd3); c++) begin @(posedge clk); #1; end
    sendReq(16'd1, 16'd1, m2, 1'b0, w);
    checks++;
    if (w !== 0) begin errors++; $display("FAIL queued_accept got wait=%0d want 0", w); end
    checks++;
    if ({out_valid, out_idx, out_last} !== {1'b1, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL queued_next_beat got valid=%b idx=%0d last=%b want valid=1 idx=0 last=1", out_valid, out_idx, out_last);
    end
    for (int c = 0; c < 50 && gotQ.size() < expQ.size(); c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (gotQ.size() != expQ.size()) begin errors++; $display("FAIL stall_count got %0d want %0d", gotQ.size(), expQ.size()); end
    while (expQ.size() > 0 && gotQ.size() > 0) begin
      e = expQ.pop_front(); g = gotQ.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL stall_beat got addr=%h xt=%h yt=%h idx=%0d last=%b err=%b want addr=%h xt=%h yt=%h idx=%0d last=%b err=%b", g.addr, g.xt, g.yt, g.idx, g.last, g.err, e.addr, e.xt, e.yt, e.idx, e.last, e.err); end
      else $display("stall beat addr=%h idx=%0d", g.addr, g.idx);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    beatT e, g;
    logic [63:0] m;
    logic [15:0] x, y;
    logic bil;
    expQ.delete(); gotQ.delete();
    done = 1'b0;
    fork
      begin
        for (int r = 0; r < 12; r++) begin
          x   = 16'($urandom);
          y   = 16'($urandom);
          bil = 1'($urandom);
          m   = makeMeta($urandom, fmtTab[$urandom_range(0, 10)], $urandom_range(0, 15),
                         $urandom_range(0, 15), 1'($urandom));
          pushModel(x, y, m, bil);
          sendReq(x, y, m, bil, w);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int c = 0; c < 200 && gotQ.size() < expQ.size(); c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (gotQ.size() != expQ.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", gotQ.size(), expQ.size()); end
    while (expQ.size() > 0 && gotQ.size() > 0) begin
      e = expQ.pop_front(); g = gotQ.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_beat got addr=%h xt=%h yt=%h idx=%0d last=%b err=%b want addr=%h xt=%h yt=%h idx=%0d last=%b err=%b", g.addr, g.xt, g.yt, g.idx, g.last, g.err, e.addr, e.xt, e.yt, e.idx, e.last, e.err); end
      else $display("b2b beat addr=%h idx=%0d err=%b", g.addr, g.idx, g.err);
    end
  endtask

  task automatic test_reset_midquad();
    int w;
    beatT e, g;
    logic [63:0] m;
    expQ.delete(); gotQ.delete();
    m = makeMeta(32'h8000, 5'b00100, 5, 5, 1'b0);
    expQ.push_back(modelBeat(16'd7, 16'd4, m, 1'b1, 0));
    expQ.push_back(modelBeat(16'd7, 16'd4, m, 1'b1, 1));
    out_ready = 1'b1;
    sendReq(16'd7, 16'd4, m, 1'b1, w);
    for (int c = 0; c < 20 && !(out_valid === 1'b1 && out_idx === 2'd2); c++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (gotQ.size() != expQ.size()) begin errors++; $display("FAIL midrst_count got %0d want %0d", gotQ.size(), expQ.size()); end
    while (expQ.size() > 0 && gotQ.size() > 0) begin
      e = expQ.pop_front(); g = gotQ.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL midrst_beat got addr=%h xt=%h yt=%h idx=%0d last=%b err=%b want addr=%h xt=%h yt=%h idx=%0d last=%b err=%b", g.addr, g.xt, g.yt, g.idx, g.last, g.err, e.addr, e.xt, e.yt, e.idx, e.last, e.err); end
      else $display("midrst beat addr=%h idx=%0d", g.addr, g.idx);
    end
  endtask

  initial begin
    test_reset();
    test_point_linear();
    test_quad_wrap_clamp();
    test_tiled();
    test_compressed();
    test_backpressure();
    test_back_to_back();
    test_reset_midquad();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
